// File: rtl/ga_generation_scheduler_pkg.sv
// Shared definitions for the GA generation scheduler: state encoding,
// population geometry and default widths.
package ga_pkg;

  localparam int POP_W        = 1875;
  localparam int IND_W        = 75;
  localparam int GEN_W_DEF    = 8;
  localparam int WDOG_W_DEF   = 16;
  localparam int WDOG_MAX_DEF = 4000;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SEL_KICK = 4'd1,
    ST_SEL_WAIT = 4'd2,
    ST_XO_KICK  = 4'd3,
    ST_XO_WAIT  = 4'd4,
    ST_MUT_KICK = 4'd5,
    ST_MUT_WAIT = 4'd6,
    ST_COMMIT   = 4'd7,
    ST_FINISH   = 4'd8,
    ST_ERROR    = 4'd9
  } state_t;

  // True in the states that wait for a stage done pulse.
  function automatic logic is_wait(input state_t s);
    return (s == ST_SEL_WAIT) || (s == ST_XO_WAIT) || (s == ST_MUT_WAIT);
  endfunction

  // True in the states that issue a stage start pulse.
  function automatic logic is_kick(input state_t s);
    return (s == ST_SEL_KICK) || (s == ST_XO_KICK) || (s == ST_MUT_KICK);
  endfunction

  // A run is in progress everywhere except IDLE and ERROR.
  function automatic logic is_busy(input state_t s);
    return (s != ST_IDLE) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/ga_generation_scheduler_watchdog.sv
// Per-stage watchdog shared by all WAIT states. clr restarts the count,
// en advances it; expire is high in the cycle where the enabled count has
// been running for MAX cycles including the current one.
module ga_stage_watchdog #(
  parameter int W   = 16,
  parameter int MAX = 4000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] count;

  // Count cycles spent waiting; hold at LAST so the counter never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = en && (count == LAST);

endmodule

// File: rtl/ga_generation_scheduler.sv
// Sequencer for one GA run: Selection -> Crossover -> Mutation -> commit,
// repeated until the latched generation limit is reached.
//
// Handshake: every *_start output is a single-cycle pulse issued in the
// matching KICK state; the stage answers with a single-cycle *_done pulse
// that is only looked at while the FSM sits in the matching WAIT state.
// pop_we and done are issued in the cycle after COMMIT / FINISH so that an
// abort seen in COMMIT or FINISH can still suppress them.
module ga_generation_scheduler
  import ga_pkg::*;
#(
  parameter int GEN_W    = GEN_W_DEF,
  parameter int WDOG_W   = WDOG_W_DEF,
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [GEN_W-1:0] max_gen,
  output logic             sel_start,
  input  logic             sel_done,
  output logic             xo_start,
  input  logic             xo_done,
  output logic             mut_start,
  input  logic             mut_done,
  output logic             pop_we,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       fsm_state
);

  state_t           state;
  state_t           nxt;
  logic [GEN_W-1:0] limit;
  logic [GEN_W-1:0] gen_next;
  logic             start_ok;
  logic             commit_ok;
  logic             wd_expire;

  assign start_ok  = start && !abort && ((state == ST_IDLE) || (state == ST_ERROR));
  assign commit_ok = (state == ST_COMMIT) && !abort;
  assign gen_next  = gen_count + 1'b1;
  assign fsm_state = state;

  ga_stage_watchdog #(
    .W   (WDOG_W),
    .MAX (WDOG_MAX)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (is_kick(state)),
    .en     (is_wait(state)),
    .expire (wd_expire)
  );

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (start) nxt = (max_gen != '0) ? ST_SEL_KICK : ST_FINISH;
        end
        ST_SEL_KICK: nxt = ST_SEL_WAIT;
        ST_SEL_WAIT: begin
          if (sel_done)       nxt = ST_XO_KICK;
          else if (wd_expire) nxt = ST_ERROR;
        end
        ST_XO_KICK: nxt = ST_XO_WAIT;
        ST_XO_WAIT: begin
          if (xo_done)        nxt = ST_MUT_KICK;
          else if (wd_expire) nxt = ST_ERROR;
        end
        ST_MUT_KICK: nxt = ST_MUT_WAIT;
        ST_MUT_WAIT: begin
          if (mut_done)       nxt = ST_COMMIT;
          else if (wd_expire) nxt = ST_ERROR;
        end
        ST_COMMIT: nxt = (gen_next == limit) ? ST_FINISH : ST_SEL_KICK;
        ST_FINISH: nxt = ST_IDLE;
        default:   nxt = ST_IDLE;
      endcase
    end
  end

  // State register, registered outputs, generation counter and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel_start <= 1'b0;
      xo_start  <= 1'b0;
      mut_start <= 1'b0;
      pop_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      gen_count <= '0;
      limit     <= '0;
    end else begin
      state     <= nxt;
      sel_start <= (nxt == ST_SEL_KICK);
      xo_start  <= (nxt == ST_XO_KICK);
      mut_start <= (nxt == ST_MUT_KICK);
      busy      <= is_busy(nxt);
      pop_we    <= commit_ok;
      done      <= (state == ST_FINISH) && !abort;
      if (start_ok) begin
        gen_count <= '0;
        limit     <= max_gen;
        err       <= 1'b0;
      end else begin
        if (commit_ok && (gen_count != '1)) gen_count <= gen_next;
        if (nxt == ST_ERROR) err <= 1'b1;
      end
    end
  end

endmodule
